game_screen_anim: RTL

Parametrised animated game-screen generator for the 96x64 OLED pixel pipeline. It succeeds the fixed single-colour game screens. Given the OLED driver's pixel coordinate, it returns a registered 16-bit RGB565 colour from one of four runtime-selectable modes: solid, flashing, bouncing box, and scrolling stripes. All animation state advances once per frame on the driver's frame-start pulse.

---
 rtl/game_screen_anim.sv | 135 +++++++++++++
 1 files changed

// File: rtl/game_screen_anim.sv
// Animated RGB565 pixel generator for the OLED pipeline: solid, flash, bouncing box and
// scrolling stripes. Animation state steps once per frame_begin; pixel output is registered.
module game_screen_anim #(
  parameter int SCREEN_W     = 96,
  parameter int SCREEN_H     = 64,
  parameter int X_W          = 7,
  parameter int Y_W          = 6,
  parameter int BOX_SIZE     = 8,
  parameter int FLASH_FRAMES = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           frame_begin,
  input  logic [1:0]     mode,
  input  logic [15:0]    colour_fg,
  input  logic [15:0]    colour_bg,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output logic [15:0]    oled_data,
  output logic [7:0]     frame_count
);

  localparam int BX_MAX = SCREEN_W - BOX_SIZE;
  localparam int BY_MAX = SCREEN_H - BOX_SIZE;
  localparam int FC_W   = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_t;

  logic [1:0]      mode_q;
  logic [FC_W-1:0] flash_cnt, flash_cnt_nxt;
  logic            flash_phase, flash_phase_nxt;
  logic [X_W-1:0]  bx, bx_nxt;
  logic [Y_W-1:0]  by, by_nxt;
  dir_t            dx, dx_nxt, dy, dy_nxt;
  logic [3:0]      scroll;

  logic [X_W:0]    x_ext, box_x_hi, stripe_sum;
  logic [Y_W:0]    y_ext, box_y_hi;
  logic            in_range, in_box, stripe_on;
  logic [15:0]     pix;

  always_comb begin
    flash_cnt_nxt   = flash_cnt + FC_W'(1);
    flash_phase_nxt = flash_phase;
    if (flash_cnt == FC_W'(FLASH_FRAMES - 1)) begin
      flash_cnt_nxt   = '0;
      flash_phase_nxt = ~flash_phase;
    end

    // Reversal and the step away from the wall happen on the same frame.
    dx_nxt = dx;
    if (dx == DIR_POS) begin
      if (bx == X_W'(BX_MAX)) begin
        dx_nxt = DIR_NEG;
        bx_nxt = bx - X_W'(1);
      end else begin
        bx_nxt = bx + X_W'(1);
      end
    end else begin
      if (bx == '0) begin
        dx_nxt = DIR_POS;
        bx_nxt = X_W'(1);
      end else begin
        bx_nxt = bx - X_W'(1);
      end
    end

    dy_nxt = dy;
    if (dy == DIR_POS) begin
      if (by == Y_W'(BY_MAX)) begin
        dy_nxt = DIR_NEG;
        by_nxt = by - Y_W'(1);
      end else begin
        by_nxt = by + Y_W'(1);
      end
    end else begin
      if (by == '0) begin
        dy_nxt = DIR_POS;
        by_nxt = Y_W'(1);
      end else begin
        by_nxt = by - Y_W'(1);
      end
    end
  end

  always_comb begin
    x_ext      = {1'b0, x};
    y_ext      = {1'b0, y};
    box_x_hi   = {1'b0, bx} + (X_W+1)'(BOX_SIZE - 1);
    box_y_hi   = {1'b0, by} + (Y_W+1)'(BOX_SIZE - 1);
    in_box     = (x_ext >= {1'b0, bx}) && (x_ext <= box_x_hi) &&
                 (y_ext >= {1'b0, by}) && (y_ext <= box_y_hi);
    // Full-width sum so a carry out of the top of x is never lost.
    stripe_sum = x_ext + (X_W+1)'(scroll);
    stripe_on  = |(stripe_sum & (X_W+1)'(8));
    in_range   = (x_ext < (X_W+1)'(SCREEN_W)) && (y_ext < (Y_W+1)'(SCREEN_H));

    case (mode_q)
      2'd0:    pix = colour_bg;
      2'd1:    pix = flash_phase ? colour_fg : colour_bg;
      2'd2:    pix = in_box ? colour_fg : colour_bg;
      default: pix = stripe_on ? colour_fg : colour_bg;
    endcase
    if (!in_range) pix = 16'h0000;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oled_data   <= 16'h0000;
      frame_count <= 8'd0;
      mode_q      <= 2'd0;
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
      bx          <= '0;
      by          <= '0;
      dx          <= DIR_POS;
      dy          <= DIR_POS;
      scroll      <= 4'd0;
    end else begin
      oled_data <= pix;
      if (frame_begin) begin
        mode_q      <= mode;
        frame_count <= frame_count + 8'd1;
        flash_cnt   <= flash_cnt_nxt;
        flash_phase <= flash_phase_nxt;
        bx          <= bx_nxt;
        by          <= by_nxt;
        dx          <= dx_nxt;
        dy          <= dy_nxt;
        scroll      <= scroll + 4'd1;
      end
    end
  end

endmodule
